register_bank_block: RTL and testbench
======================================

Name: register_bank_block

Overview:
- Decode-stage register file for the 16-bit MIPS-style pipeline: 32 x 16-bit general registers, two combinational read ports and one write port.
- The write port is fed from the data-memory stage (ans_dm at address RW_dm).
- Each read port has a 4:1 forwarding mux selecting the register value or a pipeline result (ex/dm/wb).
- Port B has an additional immediate-select mux; outputs A and B drive the execute-stage operands.

Parameters:
- DATA_W, 16, width of registers, results, immediate and outputs.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers (2**ADDR_W).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- ans_ex  input  DATA_W  execute-stage result (forwarding source).
- ans_dm  input  DATA_W  data-memory-stage result; also register write data.
- ans_wb  input  DATA_W  write-back-stage result (forwarding source).
- imm  input  DATA_W  immediate operand for port B.
- RA  input  ADDR_W  read address, port A.
- RB  input  ADDR_W  read address, port B.
- RW_dm  input  ADDR_W  write address.
- mux_sel_A  input  2  port A source select.
- mux_sel_B  input  2  port B source select.
- imm_sel  input  1  1 = B takes imm; 0 = B takes forwarding-mux B output.
- A  output  DATA_W  operand A.
- B  output  DATA_W  operand B.

Behaviour:
- Reset: on a rising clk edge with rst=1, all 32 registers clear to 0x0000. No write occurs in that cycle. A and B follow the combinational rules immediately (e.g. sel 00 reads 0x0000).
- Write port:
  - Every rising edge with rst=0 performs regs[RW_dm] <= ans_dm. There is no separate write enable.
  - Register 0 is hardwired to 0x0000; writes with RW_dm=0 are discarded.
- Read ports are combinational (zero latency): RA_data = regs[RA], RB_data = regs[RB]; address 0 always reads 0x0000.
- Read-during-write to the same address in the same cycle returns the OLD register contents. The new value is visible after the edge. Same-cycle bypass is the job of mux_sel = 10.
- Forwarding mux A, with B identical using mux_sel_B / RB_data:
  - 00 -> RA_data
  - 01 -> ans_ex
  - 10 -> ans_dm
  - 11 -> ans_wb
- B = imm_sel ? imm : mux_B_output. imm_sel has priority over mux_sel_B.
- A and B are purely combinational from inputs and register state; no output registers.
- RA = RB is legal; both ports return identical register data.
- All widths are exact; no sign extension or truncation inside the block.

Test Plan:
- Reset: assert rst one edge, deassert. RA=5, RB=6, mux_sel_A=00, mux_sel_B=00, imm_sel=0 -> A=0x0000, B=0x0000.
- Immediate: imm=0xFFFF, imm_sel=1, mux_sel_B=01, ans_ex=0xC000 -> B=0xFFFF. Then imm_sel=0 -> B=0xC000.
- Write then read: RW_dm=7, ans_dm=0xD000, one rising edge. Then RB=7, mux_sel_B=00, imm_sel=0 -> B=0xD000. Before that edge, B=0x0000 (old value; read-during-write).
- Forwarding: ans_ex=0xC000, ans_dm=0xD000, ans_wb=0xE000. Step mux_sel_A through 00/01/10/11 with RA=7 holding 0x1234 -> A = 0x1234, 0xC000, 0xD000, 0xE000. Repeat the same on B.
- Register 0: RW_dm=0, ans_dm=0xABCD, clock. RA=0, mux_sel_A=00 -> A=0x0000.
- Reset mid-operation: load r7=0xD000, then rst=1 on one edge while RW_dm=7 -> r7 reads 0x0000 after the edge (reset wins over write).

Source files
------------

// File: rtl/register_bank_block.sv
// -----------------------------------------------------------------------------
// register_bank_block
//
// Decode-stage register file for the 16-bit MIPS-style pipeline.
// 32 x DATA_W general registers with two combinational read ports and one
// write port fed from the data-memory stage. Each read port passes through a
// 4:1 forwarding mux (register / ex / dm / wb result). Port B additionally
// has an immediate-select mux in front of the execute stage.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset (clears all registers)
//   ans_ex     in   DATA_W  execute-stage result (forwarding source)
//   ans_dm     in   DATA_W  data-memory-stage result, also the write data
//   ans_wb     in   DATA_W  write-back-stage result (forwarding source)
//   imm        in   DATA_W  immediate operand for port B
//   RA         in   ADDR_W  read address, port A
//   RB         in   ADDR_W  read address, port B
//   RW_dm      in   ADDR_W  write address (written every non-reset edge)
//   mux_sel_A  in   2       port A source: 00 reg, 01 ex, 10 dm, 11 wb
//   mux_sel_B  in   2       port B source: same encoding as port A
//   imm_sel    in   1       1: B takes imm, 0: B takes forwarding mux B
//   A          out  DATA_W  operand A (combinational)
//   B          out  DATA_W  operand B (combinational)
// -----------------------------------------------------------------------------
module register_bank_block #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW_dm,
  input  logic [1:0]        mux_sel_A,
  input  logic [1:0]        mux_sel_B,
  input  logic              imm_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] ra_data_s;
  logic [DATA_W-1:0] rb_data_s;
  logic [DATA_W-1:0] mux_a_s;
  logic [DATA_W-1:0] mux_b_s;

  // Register storage: reset clears everything and suppresses that cycle's
  // write; otherwise the dm-stage result is written unconditionally, except
  // that writes aimed at r0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else if (RW_dm != ZERO_ADDR) begin
      regs_r[RW_dm] <= ans_dm;
    end
  end

  // Combinational read ports. No write bypass here: a same-cycle write is only
  // visible after the edge, and forwarding select 10 covers the bypass case.
  always_comb begin
    ra_data_s = ZERO_DATA;
    rb_data_s = ZERO_DATA;
    if (RA == ZERO_ADDR) begin
      ra_data_s = ZERO_DATA;
    end else begin
      ra_data_s = regs_r[RA];
    end
    if (RB == ZERO_ADDR) begin
      rb_data_s = ZERO_DATA;
    end else begin
      rb_data_s = regs_r[RB];
    end
  end

  // Forwarding mux for port A.
  always_comb begin
    mux_a_s = ZERO_DATA;
    case (mux_sel_A)
      2'b00:   mux_a_s = ra_data_s;
      2'b01:   mux_a_s = ans_ex;
      2'b10:   mux_a_s = ans_dm;
      2'b11:   mux_a_s = ans_wb;
      default: mux_a_s = ZERO_DATA;
    endcase
  end

  // Forwarding mux for port B.
  always_comb begin
    mux_b_s = ZERO_DATA;
    case (mux_sel_B)
      2'b00:   mux_b_s = rb_data_s;
      2'b01:   mux_b_s = ans_ex;
      2'b10:   mux_b_s = ans_dm;
      2'b11:   mux_b_s = ans_wb;
      default: mux_b_s = ZERO_DATA;
    endcase
  end

  // Operand outputs; the immediate overrides whatever forwarding mux B picked.
  always_comb begin
    A = mux_a_s;
    B = mux_b_s;
    if (imm_sel) begin
      B = imm;
    end else begin
      B = mux_b_s;
    end
  end

endmodule

// File: tb/tb_register_bank_block.sv
module tb_register_bank_block;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [DW-1:0] ans_ex, ans_dm, ans_wb, imm;
  logic [AW-1:0] RA, RB, RW_dm;
  logic [1:0]    mux_sel_A, mux_sel_B;
  logic          imm_sel;
  logic [DW-1:0] A, B;

  register_bank_block dut (
    .clk(clk), .rst(rst),
    .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb), .imm(imm),
    .RA(RA), .RB(RB), .RW_dm(RW_dm),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .imm_sel(imm_sel),
    .A(A), .B(B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t sb_q[$];

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model: architectural register contents.
  logic [DW-1:0] mdl [32];
  bit            mdl_valid = 1'b0;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] addr);
    if (addr == 5'd0) return 16'h0000;
    return mdl[addr];
  endfunction

  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] r,
                                        input logic [DW-1:0] ex, input logic [DW-1:0] dm,
                                        input logic [DW-1:0] wb);
    logic [DW-1:0] src [4];
    src[0] = r; src[1] = ex; src[2] = dm; src[3] = wb;
    return src[sel];
  endfunction

  // One clock cycle of stimulus: drive inputs, optionally queue the expected
  // outputs for this cycle, then advance the model across the edge.
  task automatic cycle(input string nm, input bit chk, input bit r,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rw,
                       input logic [DW-1:0] ex, input logic [DW-1:0] dm, input logic [DW-1:0] wb,
                       input logic [DW-1:0] im, input logic [1:0] sa, input logic [1:0] sbs,
                       input bit isel);
    exp_t e;
    rst = r; RA = ra; RB = rb; RW_dm = rw;
    ans_ex = ex; ans_dm = dm; ans_wb = wb; imm = im;
    mux_sel_A = sa; mux_sel_B = sbs; imm_sel = isel;
    if (chk && mdl_valid) begin
      e.name = nm;
      e.a = pick(sa, rd(ra), ex, dm, wb);
      e.b = isel ? im : pick(sbs, rd(rb), ex, dm, wb);
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
      mdl_valid = 1'b1;
    end else if (rw != 5'd0) begin
      mdl[rw] = dm;
    end
    #1;
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      if (A !== e.a || B !== e.b) begin
        fails++;
        $display("FAIL %s: A=%h B=%h expected A=%h B=%h", e.name, A, B, e.a, e.b);
      end else begin
        passed++;
      end
    end
  end

  initial begin
    rst = 1'b0; RA = 5'd0; RB = 5'd0; RW_dm = 5'd0;
    ans_ex = 16'h0; ans_dm = 16'h0; ans_wb = 16'h0; imm = 16'h0;
    mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b0;
    @(posedge clk); #1;

    // Reset, then confirm reads of cleared registers.
    cycle("rst_edge", 1'b0, 1'b1, 5'd5, 5'd6, 5'd0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    cycle("reset_state", 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    // Immediate priority over mux B, then release.
    cycle("imm_sel1", 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 16'hC000, 16'h0, 16'h0, 16'hFFFF, 2'b00, 2'b01, 1'b1);
    cycle("imm_sel0", 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 16'hC000, 16'h0, 16'h0, 16'hFFFF, 2'b00, 2'b01, 1'b0);
    // Read-during-write returns old value; new value after the edge.
    cycle("rdw_old", 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 16'h0, 16'hD000, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    cycle("write_read", 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 16'h0, 16'hD000, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    // Load r7=0x1234, then sweep forwarding selects on A and B.
    cycle("load_r7", 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 16'h0, 16'h1234, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    for (int s = 0; s < 4; s++)
      cycle("fwd_A", 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 16'hC000, 16'hD000, 16'hE000, 16'h0, s[1:0], 2'b00, 1'b0);
    for (int s = 0; s < 4; s++)
      cycle("fwd_B", 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 16'hC000, 16'hD000, 16'hE000, 16'h0, 2'b00, s[1:0], 1'b0);
    // Writes to r0 are discarded.
    cycle("r0_write", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 16'hABCD, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    cycle("r0_read", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    // Reset wins over a simultaneous write.
    cycle("load_r7b", 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 16'h0, 16'hD000, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    cycle("rst_mid", 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 16'h0, 16'h5555, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    cycle("after_rst", 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit            r;
      logic [AW-1:0] rw;
      r  = ($urandom_range(0, 59) == 0);
      rw = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      cycle("random", 1'b1, r, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rw,
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
